// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: load-use bubbles, memory-wait holds,
// branch redirects and drained interrupt entry. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned DRAIN_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_raddr,
    input  logic [4:0]  id_rs2_raddr,
    input  logic [4:0]  ex_rd_waddr,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_addr,
    input  logic        mem_busy,
    input  logic        irq_req,
    input  logic [31:0] trap_vec,
    output logic        hold_pc,
    output logic        hold_ifid,
    output logic        hold_idex,
    output logic        hold_exmem,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        jump_en,
    output logic [31:0] jump_addr,
    output logic        irq_ack,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        DRAIN = 2'd2,
        TRAP  = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_DEPTH);

    state_t     state, state_nxt;
    logic [2:0] drain_cnt, drain_cnt_nxt;
    logic       load_use;

    assign load_use = ex_is_load && (ex_rd_waddr != 5'd0) &&
                      ((ex_rd_waddr == id_rs1_raddr) || (ex_rd_waddr == id_rs2_raddr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        hold_pc       = 1'b0;
        hold_ifid     = 1'b0;
        hold_idex     = 1'b0;
        hold_exmem    = 1'b0;
        flush_ifid    = 1'b0;
        flush_idex    = 1'b0;
        jump_en       = 1'b0;
        jump_addr     = 32'd0;
        irq_ack       = 1'b0;

        if (!rst) begin
            if (mem_busy) begin
                // Whole pipe freezes; only RUN records that it is waiting.
                hold_pc    = 1'b1;
                hold_ifid  = 1'b1;
                hold_idex  = 1'b1;
                hold_exmem = 1'b1;
                if (state == RUN) begin
                    state_nxt = MWAIT;
                end
            end else begin
                case (state)
                    RUN, MWAIT: begin
                        if (ex_branch_taken) begin
                            jump_en    = 1'b1;
                            jump_addr  = ex_branch_addr;
                            flush_ifid = 1'b1;
                            flush_idex = 1'b1;
                        end else if (state == RUN && irq_req) begin
                            state_nxt     = DRAIN;
                            drain_cnt_nxt = DRAIN_INIT;
                        end else if (load_use) begin
                            hold_pc    = 1'b1;
                            hold_ifid  = 1'b1;
                            flush_idex = 1'b1;
                        end
                        if (state == MWAIT) begin
                            state_nxt = RUN;
                        end
                    end

                    DRAIN: begin
                        if (ex_branch_taken) begin
                            jump_en    = 1'b1;
                            jump_addr  = ex_branch_addr;
                            flush_ifid = 1'b1;
                            flush_idex = 1'b1;
                        end else if (load_use) begin
                            hold_pc    = 1'b1;
                            hold_ifid  = 1'b1;
                            flush_idex = 1'b1;
                        end else begin
                            hold_pc    = 1'b1;
                            flush_ifid = 1'b1;
                        end
                        // Trap entry is committed once draining starts; irq_req is not re-checked.
                        if (drain_cnt <= 3'd1) begin
                            state_nxt     = TRAP;
                            drain_cnt_nxt = 3'd0;
                        end else begin
                            drain_cnt_nxt = drain_cnt - 3'd1;
                        end
                    end

                    TRAP: begin
                        jump_en    = 1'b1;
                        jump_addr  = trap_vec;
                        irq_ack    = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_nxt  = RUN;
                    end

                    default: begin
                        state_nxt = RUN;
                    end
                endcase
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (hold_pc && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_idex && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues the expected outputs of each
// cycle and a negedge monitor pops and compares them.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
    logic        ex_is_load, ex_branch_taken, mem_busy, irq_req;
    logic [31:0] ex_branch_addr, trap_vec;
    logic        hold_pc, hold_ifid, hold_idex, hold_exmem;
    logic        flush_ifid, flush_idex, jump_en, irq_ack;
    logic [31:0] jump_addr, stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [3:0]  h;
        logic [1:0]  f;
        logic        je;
        logic [31:0] ja;
        logic        ack;
        logic        chk;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic [39:0] act_v, exp_v;

    pipe_ctrl #(.DRAIN_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_raddr    (id_rs1_raddr),
        .id_rs2_raddr    (id_rs2_raddr),
        .ex_rd_waddr     (ex_rd_waddr),
        .ex_is_load      (ex_is_load),
        .ex_branch_taken (ex_branch_taken),
        .ex_branch_addr  (ex_branch_addr),
        .mem_busy        (mem_busy),
        .irq_req         (irq_req),
        .trap_vec        (trap_vec),
        .hold_pc         (hold_pc),
        .hold_ifid       (hold_ifid),
        .hold_idex       (hold_idex),
        .hold_exmem      (hold_exmem),
        .flush_ifid      (flush_ifid),
        .flush_idex      (flush_idex),
        .jump_en         (jump_en),
        .jump_addr       (jump_addr),
        .irq_ack         (irq_ack),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            act_v = {hold_pc, hold_ifid, hold_idex, hold_exmem, flush_ifid, flush_idex,
                     jump_en, jump_addr, irq_ack};
            exp_v = {e.h, e.f, e.je, e.ja, e.ack};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL %s: got h=%b f=%b je=%b ja=%h ack=%b, want h=%b f=%b je=%b ja=%h ack=%b",
                         e.nm, act_v[39:36], act_v[35:34], act_v[33], act_v[32:1], act_v[0],
                         e.h, e.f, e.je, e.ja, e.ack);
            end
            if (e.chk) begin
                total++;
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    bad++;
                    $display("FAIL %s_cnt: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                             e.nm, stall_cnt, flush_cnt, e.sc, e.fc);
                end
            end
        end
    end

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [3:0] h, input logic [1:0] f,
                       input logic je, input logic [31:0] ja, input logic ack,
                       input logic chk = 1'b0, input logic [31:0] sc = 32'd0,
                       input logic [31:0] fc = 32'd0);
        exp_t x;
        x.nm = nm; x.h = h; x.f = f; x.je = je; x.ja = ja; x.ack = ack;
        x.chk = chk; x.sc = sc; x.fc = fc;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst             = 1'b0;
        id_rs1_raddr    = 5'd0;
        id_rs2_raddr    = 5'd0;
        ex_rd_waddr     = 5'd0;
        ex_is_load      = 1'b0;
        ex_branch_taken = 1'b0;
        ex_branch_addr  = 32'd0;
        mem_busy        = 1'b0;
        irq_req         = 1'b0;
        trap_vec        = 32'h0000_0100;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_is_load   = 1'b1;
        ex_rd_waddr  = rd;
        id_rs1_raddr = rs1;
        id_rs2_raddr = rs2;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        ex_branch_taken = 1'b1;
        ex_branch_addr  = 32'hDEAD_BEEF;
        irq_req = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_outputs", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0);

        // load-use
        idle(); cyc("idle", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        set_lu(5'd5, 5'd1, 5'd5); cyc("lu_rs2", 4'b1100, 2'b01, 1'b0, 32'd0, 1'b0);
        idle(); cyc("lu_release", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        set_lu(5'd0, 5'd0, 5'd0); cyc("lu_x0", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        set_lu(5'd7, 5'd7, 5'd3); cyc("lu_rs1", 4'b1100, 2'b01, 1'b0, 32'd0, 1'b0);
        ex_is_load = 1'b0; cyc("no_load", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // branch
        idle(); ex_branch_taken = 1'b1; ex_branch_addr = 32'h8000_0040;
        cyc("branch", 4'b0000, 2'b11, 1'b1, 32'h8000_0040, 1'b0);
        set_lu(5'd9, 5'd9, 5'd9);
        cyc("branch_over_lu", 4'b0000, 2'b11, 1'b1, 32'h8000_0040, 1'b0);

        // mem_busy over load-use, bubble on first free cycle
        idle(); set_lu(5'd4, 5'd4, 5'd2); mem_busy = 1'b1;
        cyc("busy1", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc("busy2", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc("busy3", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b0; cyc("busy_bubble", 4'b1100, 2'b01, 1'b0, 32'd0, 1'b0);
        idle(); cyc("busy_done", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // irq: two drain cycles then trap
        irq_req = 1'b1; cyc("irq_entry", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        irq_req = 1'b0; cyc("drain1", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        cyc("drain2", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        cyc("trap", 4'b0000, 2'b11, 1'b1, 32'h0000_0100, 1'b1);
        cyc("after_trap", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // irq with mem_busy during drain and trap
        irq_req = 1'b1; cyc("irq_b_entry", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        irq_req = 1'b0; cyc("irq_b_drain1", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b1; cyc("irq_b_busy", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b0; cyc("irq_b_drain2", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b1; cyc("irq_b_trap_busy", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b0; trap_vec = 32'h0000_0200;
        cyc("irq_b_trap", 4'b0000, 2'b11, 1'b1, 32'h0000_0200, 1'b1);
        idle(); cyc("irq_b_after", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // branch while draining keeps the drain going
        irq_req = 1'b1; cyc("irq_c_entry", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        irq_req = 1'b0; ex_branch_taken = 1'b1; ex_branch_addr = 32'h0000_1234;
        cyc("irq_c_branch", 4'b0000, 2'b11, 1'b1, 32'h0000_1234, 1'b0);
        ex_branch_taken = 1'b0; cyc("irq_c_drain2", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        cyc("irq_c_trap", 4'b0000, 2'b11, 1'b1, 32'h0000_0100, 1'b1);
        cyc("irq_c_after", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // reset during drain cancels the trap
        irq_req = 1'b1; cyc("irq_d_entry", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        irq_req = 1'b0; cyc("irq_d_drain1", 4'b1000, 2'b10, 1'b0, 32'd0, 1'b0);
        rst = 1'b1; cyc("rst_in_drain", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        rst = 1'b0; cyc("post_rst1", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc("post_rst2", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc("post_rst3", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0);

        // performance counters: 4 stall cycles, 2 of them also flushing
        rst = 1'b1; cyc("perf_rst", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0);
        idle(); mem_busy = 1'b1;
        cyc("perf_busy1", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        cyc("perf_busy2", 4'b1111, 2'b00, 1'b0, 32'd0, 1'b0);
        mem_busy = 1'b0; set_lu(5'd6, 5'd6, 5'd1);
        cyc("perf_lu1", 4'b1100, 2'b01, 1'b0, 32'd0, 1'b0);
        cyc("perf_lu2", 4'b1100, 2'b01, 1'b0, 32'd0, 1'b0);
        idle();
        cyc("perf_check", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1,
            PERF ? 32'd4 : 32'd0, PERF ? 32'd2 : 32'd0);
        cyc("perf_hold", 4'b0000, 2'b00, 1'b0, 32'd0, 1'b0, 1'b1,
            PERF ? 32'd4 : 32'd0, PERF ? 32'd2 : 32'd0);

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_DEPTH, default 2, meaning cycles of drain before trap entry (range 1..7).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 id_rs1_raddr, id_rs2_raddr  in  5 each  source register addresses of the instruction in ID.
REQ-005 ex_rd_waddr  in  5  destination register of the instruction in EX; ex_is_load  in  1  EX instruction is a load.
REQ-006 ex_branch_taken  in  1  EX resolved a taken branch/jump; ex_branch_addr  in  32  its target.
REQ-007 mem_busy  in  1  data memory not ready this cycle; irq_req  in  1  level interrupt request; trap_vec  in  32  trap target.
REQ-008 hold_pc, hold_ifid, hold_idex, hold_exmem  out  1 each  stage register hold enables.
REQ-009 flush_ifid, flush_idex  out  1 each  load NOP/reset value into the stage register.
REQ-010 jump_en  out  1; jump_addr  out  32  PC redirect; irq_ack  out  1  one-cycle trap-taken pulse.
REQ-011 stall_cnt, flush_cnt  out  32 each  performance counters.

Function
REQ-012 SHALL implement FSM states RUN, MWAIT, DRAIN, TRAP; hold/flush/jump outputs combinational from state and inputs, counters and state registered.
REQ-013 Load-use hazard = ex_is_load & ex_rd_waddr!=0 & (ex_rd_waddr==id_rs1_raddr | ex_rd_waddr==id_rs2_raddr).
REQ-014 Priority each cycle: mem_busy > TRAP > ex_branch_taken > irq entry > load-use.
REQ-015 Any state with mem_busy=1: all four holds=1, flushes=0, jump_en=0; FSM state, drain counter frozen (RUN moves to MWAIT).
REQ-016 MWAIT: when mem_busy=0 holds deassert in that same cycle and next state is RUN.
REQ-017 RUN, ex_branch_taken=1: jump_en=1, jump_addr=ex_branch_addr, flush_ifid=flush_idex=1, holds=0, state RUN.
REQ-018 RUN, load-use only: hold_pc=hold_ifid=1, flush_idex=1 (one bubble), hold_idex=hold_exmem=0, exactly one cycle.
REQ-019 RUN, irq_req=1 and no higher-priority event: next state DRAIN, drain counter loaded with DRAIN_DEPTH.
REQ-020 DRAIN: hold_pc=1, flush_ifid=1; counter decrements per unfrozen cycle; next state TRAP when counter reaches 1 and decrements; branch in DRAIN still drives jump_en per REQ-017 without leaving DRAIN.
REQ-021 TRAP: jump_en=1, jump_addr=trap_vec, irq_ack=1, flush_ifid=flush_idex=1, one cycle, then RUN.
REQ-022 irq_req deasserting during DRAIN SHALL NOT abort the trap.
REQ-023 jump_addr SHALL be 0 when jump_en=0.

Reset
REQ-024 rst=1 SHALL force, asynchronously: state RUN, drain counter 0, stall_cnt=flush_cnt=0.
REQ-025 While rst=1 all hold, flush, jump_en, irq_ack outputs SHALL be 0 and jump_addr 0.
REQ-026 Reset mid-DRAIN SHALL cancel the pending trap; no irq_ack after release unless irq_req re-sampled.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN defined: stall_cnt increments each cycle hold_pc=1, flush_cnt each cycle flush_idex=1, both saturating at 0xFFFFFFFF.
REQ-028 PIPE_CTRL_PERF_EN undefined: no counter registers; stall_cnt and flush_cnt tied to 0.

Verification
REQ-029 ex_is_load=1, ex_rd_waddr=5, id_rs2_raddr=5 one cycle -> hold_pc=hold_ifid=flush_idex=1 that cycle only; with ex_rd_waddr=0 -> no stall.
REQ-030 ex_branch_taken=1, ex_branch_addr=0x80000040 -> jump_en=1, jump_addr=0x80000040, flush_ifid=flush_idex=1 same cycle.
REQ-031 mem_busy high 3 cycles during a load-use hazard -> all holds=1 for 3 cycles, no flush, then bubble on first non-busy cycle.
REQ-032 irq_req pulse, trap_vec=0x00000100, DRAIN_DEPTH=2 -> 2 DRAIN cycles, then one TRAP cycle with irq_ack=1, jump_addr=0x100; mem_busy in DRAIN extends by busy cycles.
REQ-033 rst asserted during DRAIN -> outputs 0 immediately, no irq_ack after release with irq_req=0.
REQ-034 PERF_EN defined: 4 stall cycles + 2 flushes -> stall_cnt=4, flush_cnt=2; undefined -> both 0.
